// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with Mealy (z) and registered (z_q) match flags.
// Define SEQDET_MATCH_COUNT_EN to add the saturating match_cnt output.
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PAT_RESET = 4'b1010,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 in_valid,
    input  logic                 overlap,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern_in,
    output logic                 z,
    output logic                 z_q
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]     match_cnt
`endif
);
    localparam int FW = $clog2(PATTERN_W + 1);

    if (PATTERN_W < 2 || PATTERN_W > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: PATTERN_W must be 2..32 and CNT_W >= 1");
    end

    logic [PATTERN_W-1:0] pat_reg;
    // Only the newest PATTERN_W-1 bits can ever take part in a match.
    logic [PATTERN_W-2:0] hist;
    logic [FW-1:0]        fill;
    logic [PATTERN_W-1:0] win;
    logic                 accept;
    logic                 hit;

    always_comb begin
        win    = {hist, x};
        accept = in_valid & ~load;
        hit    = accept & (fill >= FW'(PATTERN_W - 1)) & (win == pat_reg);
        z      = hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg <= PAT_RESET;
            hist    <= '0;
            fill    <= '0;
            z_q     <= 1'b0;
        end else begin
            z_q <= hit;
            if (load) begin
                pat_reg <= pattern_in;
                hist    <= '0;
                fill    <= '0;
            end else if (in_valid) begin
                if (hit && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= win[PATTERN_W-2:0];
                    fill <= (fill == FW'(PATTERN_W)) ? fill : fill + FW'(1);
                end
            end
        end
    end

`ifdef SEQDET_MATCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            match_cnt <= '0;
        else if (load)
            match_cnt <= '0;
        else if (hit && match_cnt != '1)
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized + directed scoreboard bench for seq_detector_param.
// The reference model keeps the accepted bit stream in a queue and matches its tail against the pattern.
module tb_seq_detector_param;
    localparam int W  = 4;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         x;
    logic         in_valid;
    logic         overlap;
    logic         load;
    logic [W-1:0] pattern_in;
    logic         z;
    logic         z_q;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [CW-1:0] match_cnt;
`endif

    seq_detector_param #(.PATTERN_W(W), .PAT_RESET(4'b1010), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .in_valid(in_valid),
        .overlap(overlap),
        .load(load),
        .pattern_in(pattern_in),
        .z(z),
        .z_q(z_q)
`ifdef SEQDET_MATCH_COUNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit z;
        bit zq;
        int cnt;
    } exp_t;

    exp_t   sb[$];
    exp_t   got_e;
    int     total = 0;
    int     bad = 0;
    bit [W-1:0] m_pat = 4'b1010;
    bit     m_hist[$];
    bit     m_prev = 0;
    int     m_cnt = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every cycle that carries a stimulus presents its Mealy and registered outputs.
    initial forever begin
        @(negedge clk);
        #3;
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check("z", z, got_e.z);
            check("z_q", z_q, got_e.zq);
`ifdef SEQDET_MATCH_COUNT_EN
            check("match_cnt", match_cnt, got_e.cnt);
`endif
        end
    end

    task automatic model_reset();
        m_pat = 4'b1010;
        m_hist.delete();
        m_prev = 0;
        m_cnt = 0;
    endtask

    task automatic step(bit xi, bit vi, bit ov, bit ld = 0, logic [W-1:0] pi = '0);
        exp_t e;
        bit hit;
        @(negedge clk);
        x = xi; in_valid = vi; overlap = ov; load = ld; pattern_in = pi;
        hit = 0;
        if (vi && !ld && m_hist.size() >= W - 1) begin
            hit = (m_pat[0] == xi);
            for (int i = 0; i < W - 1; i++)
                if (m_hist[m_hist.size() - (W - 1) + i] != m_pat[W-1-i]) hit = 0;
        end
        e.z = hit; e.zq = m_prev; e.cnt = m_cnt;
        sb.push_back(e);
        if (ld) begin
            m_pat = pi;
            m_hist.delete();
            m_cnt = 0;
        end else if (vi) begin
            if (hit && !ov) m_hist.delete();
            else begin
                m_hist.push_back(xi);
                if (m_hist.size() > W - 1) void'(m_hist.pop_front());
            end
            if (hit && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        m_prev = hit;
    endtask

    task automatic seq(bit [15:0] bits, int n, bit ov);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1, ov);
    endtask

    // Reset lands mid-cycle while the inputs would otherwise complete a match.
    task automatic async_reset(bit want_z_before);
        @(negedge clk);
        x = 0; in_valid = 1; load = 0; overlap = 1;
        #1 check("pre_reset_z", z, want_z_before);
        #1 reset = 1;
        #1;
        check("reset_z", z, 0);
        check("reset_z_q", z_q, 0);
`ifdef SEQDET_MATCH_COUNT_EN
        check("reset_match_cnt", match_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        reset = 0; in_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] p;
        reset = 1; x = 0; in_valid = 0; overlap = 1; load = 0; pattern_in = '0;
        #3;
        check("init_z", z, 0);
        check("init_z_q", z_q, 0);
`ifdef SEQDET_MATCH_COUNT_EN
        check("init_match_cnt", match_cnt, 0);
`endif
        @(negedge clk);
        reset = 0;
        seq(16'b101010, 6, 1);
        step(0, 0, 0, 1, 4'b1010);
        seq(16'b101010, 6, 0);
        step(0, 0, 1, 1, 4'b1010);
        seq(16'b10, 2, 1);
        repeat (3) step($urandom_range(0, 1), 0, 1);
        seq(16'b10, 2, 1);
        seq(16'b101, 3, 1);
        step(0, 1, 1, 1, 4'b0110);
        seq(16'b0110, 4, 1);
        seq(16'b011, 3, 1);
        async_reset(1);
        step(0, 1, 1);
        seq(16'b1010, 4, 1);
        step(0, 1, 1, 1, 4'b1111);
        repeat (260) step(1, 1, 1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: p = 4'b1010;
                1: p = 4'b1111;
                2: p = 4'b0110;
                default: p = W'($urandom);
            endcase
            step($urandom_range(0, 1), $urandom_range(0, 9) < 8, $urandom_range(0, 1),
                 $urandom_range(0, 99) < 3, p);
        end
        @(negedge clk);
        in_valid = 0; load = 0;
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
